// File: rtl/fifo_ctl_sync.sv
// Single-clock FIFO controller for an external dual-port RAM: pointers, fill counts,
// status flags, overflow/underflow reporting and a high-watermark statistic.
module fifo_ctl_sync #(
  parameter int FIFODEPTH     = 16,
  parameter int AFULL_THRESH  = FIFODEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int OVF_MODE      = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wstb_i,
  input  logic                         rstb_i,
  input  logic                         flush_i,
  input  logic                         clr_stat_i,
  output logic [$clog2(FIFODEPTH)-1:0] waddr_o,
  output logic [$clog2(FIFODEPTH)-1:0] raddr_o,
  output logic                         wen_o,
  output logic [$clog2(FIFODEPTH):0]   numfilled_o,
  output logic [$clog2(FIFODEPTH):0]   numempty_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         afull_o,
  output logic                         aempty_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  output logic                         ovf_sticky_o,
  output logic                         udf_sticky_o,
  output logic [$clog2(FIFODEPTH):0]   hiwater_o
);

  localparam int   FIFOPTRWIDTH = $clog2(FIFODEPTH);
  localparam int   PW           = FIFOPTRWIDTH;
  localparam int   CW           = FIFOPTRWIDTH + 1;
  localparam logic OVW_EN       = (OVF_MODE != 0);

  logic [PW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [CW-1:0] cnt_q, cnt_d, nempty_q, nempty_d, hiw_q, hiw_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, udf_q, ovf_stk_q, udf_stk_q;
  logic          rd_acc, wr_acc, ovw, rd_adv, ovf_evt, udf_evt;

  // Depth need not be a power of two, so wrap explicitly rather than truncating.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFODEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_acc  = rstb_i & ~empty_q & ~flush_i & ~rst_i;
    ovw     = wstb_i & ~rstb_i & full_q & OVW_EN & ~flush_i & ~rst_i;
    wr_acc  = wstb_i & ~flush_i & ~rst_i & (~full_q | rstb_i | OVW_EN);
    rd_adv  = rd_acc | ovw;
    ovf_evt = wstb_i & ~rstb_i & full_q & ~flush_i;
    udf_evt = rstb_i & empty_q & ~flush_i;

    cnt_d   = flush_i ? '0 : cnt_q + CW'(wr_acc) - CW'(rd_adv);
    nempty_d = CW'(FIFODEPTH) - cnt_d;
    waddr_d = flush_i ? '0 : (wr_acc ? ptr_inc(waddr_q) : waddr_q);
    raddr_d = flush_i ? '0 : (rd_adv ? ptr_inc(raddr_q) : raddr_q);

    if (clr_stat_i)          hiw_d = cnt_d;
    else if (cnt_d > hiw_q)  hiw_d = cnt_d;
    else                     hiw_d = hiw_q;
  end

  assign wen_o = wr_acc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waddr_q   <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      nempty_q  <= CW'(FIFODEPTH);
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_stk_q <= 1'b0;
      udf_stk_q <= 1'b0;
      hiw_q     <= '0;
    end else begin
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      cnt_q     <= cnt_d;
      nempty_q  <= nempty_d;
      // Flags follow the next-state count so they move together with numfilled.
      full_q    <= (cnt_d == CW'(FIFODEPTH));
      empty_q   <= (cnt_d == '0);
      afull_q   <= (cnt_d >= CW'(AFULL_THRESH));
      aempty_q  <= (cnt_d <= CW'(AEMPTY_THRESH));
      ovf_q     <= ovf_evt;
      udf_q     <= udf_evt;
      ovf_stk_q <= (ovf_stk_q & ~clr_stat_i) | ovf_evt;
      udf_stk_q <= (udf_stk_q & ~clr_stat_i) | udf_evt;
      hiw_q     <= hiw_d;
    end
  end

  assign waddr_o      = waddr_q;
  assign raddr_o      = raddr_q;
  assign numfilled_o  = cnt_q;
  assign numempty_o   = nempty_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign afull_o      = afull_q;
  assign aempty_o     = aempty_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = udf_q;
  assign ovf_sticky_o = ovf_stk_q;
  assign udf_sticky_o = udf_stk_q;
  assign hiwater_o    = hiw_q;

endmodule

// File: tb/tb_fifo_ctl_sync.sv
// Directed bench for fifo_ctl_sync at depth 6: one drop-new and one overwrite-oldest
// instance driven by the same stimulus.
module tb_fifo_ctl_sync;

  localparam int D  = 6;
  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;

  logic clk = 1'b0;
  logic rst, wstb, rstb, flush, clr;

  logic [PW-1:0] waddr0, raddr0, waddr1, raddr1;
  logic [CW-1:0] nf0, ne0, hw0, nf1, ne1, hw1;
  logic wen0, full0, empty0, afull0, aempty0, ovf0, udf0, ovs0, uds0;
  logic wen1, full1, empty1, afull1, aempty1, ovf1, udf1, ovs1, uds1;

  int n_checks = 0;
  int n_errors = 0;
  int wp;

  always #5 clk = ~clk;

  fifo_ctl_sync #(.FIFODEPTH(D), .AFULL_THRESH(4), .AEMPTY_THRESH(2), .OVF_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wstb_i(wstb), .rstb_i(rstb), .flush_i(flush), .clr_stat_i(clr),
    .waddr_o(waddr0), .raddr_o(raddr0), .wen_o(wen0), .numfilled_o(nf0), .numempty_o(ne0),
    .full_o(full0), .empty_o(empty0), .afull_o(afull0), .aempty_o(aempty0),
    .overflow_o(ovf0), .underflow_o(udf0), .ovf_sticky_o(ovs0), .udf_sticky_o(uds0),
    .hiwater_o(hw0));

  fifo_ctl_sync #(.FIFODEPTH(D), .AFULL_THRESH(4), .AEMPTY_THRESH(2), .OVF_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wstb_i(wstb), .rstb_i(rstb), .flush_i(flush), .clr_stat_i(clr),
    .waddr_o(waddr1), .raddr_o(raddr1), .wen_o(wen1), .numfilled_o(nf1), .numempty_o(ne1),
    .full_o(full1), .empty_o(empty1), .afull_o(afull1), .aempty_o(aempty1),
    .overflow_o(ovf1), .underflow_o(udf1), .ovf_sticky_o(ovs1), .udf_sticky_o(uds1),
    .hiwater_o(hw1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c);
    wstb = w; rstb = r; flush = f; clr = c;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " waddr"}, 32'(waddr0), 0);
    chk({tag, " raddr"}, 32'(raddr0), 0);
    chk({tag, " numfilled"}, 32'(nf0), 0);
    chk({tag, " numempty"}, 32'(ne0), D);
    chk({tag, " empty"}, 32'(empty0), 1);
    chk({tag, " aempty"}, 32'(aempty0), 1);
    chk({tag, " full"}, 32'(full0), 0);
    chk({tag, " afull"}, 32'(afull0), 0);
    chk({tag, " overflow"}, 32'(ovf0), 0);
    chk({tag, " underflow"}, 32'(udf0), 0);
    chk({tag, " ovf_sticky"}, 32'(ovs0), 0);
    chk({tag, " udf_sticky"}, 32'(uds0), 0);
    chk({tag, " hiwater"}, 32'(hw0), 0);
    chk({tag, " hiwater1"}, 32'(hw1), 0);
    chk({tag, " waddr1"}, 32'(waddr1), 0);
  endtask

  initial begin
    rst = 1'b1; wstb = 1'b0; rstb = 1'b0; flush = 1'b0; clr = 1'b0;
    tick(); tick();
    chk_reset_state("rst");
    rst = 1'b0;

    // Fill to full, watching thresholds at every step.
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 0);
      chk("fill wen", 32'(wen0), 1);
      chk("fill waddr", 32'(waddr0), i);
      tick();
      chk("fill numfilled", 32'(nf0), i + 1);
      chk("fill numempty", 32'(ne0), D - 1 - i);
      chk("fill full", 32'(full0), (i == D - 1) ? 1 : 0);
      chk("fill afull", 32'(afull0), (i + 1 >= 4) ? 1 : 0);
      chk("fill aempty", 32'(aempty0), (i + 1 <= 2) ? 1 : 0);
      chk("fill empty", 32'(empty0), 0);
      chk("fill hiwater", 32'(hw0), i + 1);
    end

    // 7th write: dropped in mode 0, overwrites oldest in mode 1.
    drive(1, 0, 0, 0);
    chk("ovf wen0", 32'(wen0), 0);
    chk("ovf wen1", 32'(wen1), 1);
    chk("ovf waddr1 pre", 32'(waddr1), 0);
    tick();
    chk("ovf pulse0", 32'(ovf0), 1);
    chk("ovf sticky0", 32'(ovs0), 1);
    chk("ovf numfilled0", 32'(nf0), D);
    chk("ovf waddr0", 32'(waddr0), 0);
    chk("ovf raddr0", 32'(raddr0), 0);
    chk("ovf pulse1", 32'(ovf1), 1);
    chk("ovw waddr1", 32'(waddr1), 1);
    chk("ovw raddr1", 32'(raddr1), 1);
    chk("ovw numfilled1", 32'(nf1), D);
    drive(0, 0, 0, 0);
    tick();
    chk("ovf pulse end", 32'(ovf0), 0);
    chk("ovf sticky held", 32'(ovs0), 1);
    drive(1, 0, 0, 0);
    tick();
    chk("ovw2 waddr1", 32'(waddr1), 2);
    chk("ovw2 raddr1", 32'(raddr1), 2);
    chk("ovw2 numfilled1", 32'(nf1), D);

    // Drain: mode 1 reads start at the oldest surviving entry.
    for (int k = 0; k < D; k++) begin
      drive(0, 1, 0, 0);
      chk("drain raddr1", 32'(raddr1), (2 + k) % D);
      chk("drain raddr0", 32'(raddr0), k);
      tick();
      chk("drain numfilled0", 32'(nf0), D - 1 - k);
    end
    chk("drain empty0", 32'(empty0), 1);
    chk("drain empty1", 32'(empty1), 1);
    chk("drain raddr0 wrap", 32'(raddr0), 0);
    chk("drain underflow", 32'(udf0), 0);

    // Simultaneous write/read on empty: write only, read rejected.
    drive(1, 1, 0, 0);
    chk("e_wr wen", 32'(wen0), 1);
    tick();
    chk("e_wr numfilled", 32'(nf0), 1);
    chk("e_wr underflow", 32'(udf0), 1);
    chk("e_wr udf_sticky", 32'(uds0), 1);
    chk("e_wr raddr", 32'(raddr0), 0);
    chk("e_wr waddr", 32'(waddr0), 1);
    chk("e_wr empty", 32'(empty0), 0);
    drive(0, 1, 0, 0);
    tick();
    chk("e_rd empty", 32'(empty0), 1);
    chk("e_rd aempty", 32'(aempty0), 1);
    chk("e_rd numfilled", 32'(nf0), 0);
    chk("e_rd underflow end", 32'(udf0), 0);

    // Wrap: 20 write/read pairs starting from pointer 1.
    wp = 1;
    for (int n = 0; n < 20; n++) begin
      drive(1, 0, 0, 0);
      tick();
      wp = (wp == D - 1) ? 0 : wp + 1;
      chk("wrap waddr", 32'(waddr0), wp);
      chk("wrap nf w", 32'(nf0), 1);
      chk("wrap err w", 32'(ovf0 | udf0), 0);
      drive(0, 1, 0, 0);
      tick();
      chk("wrap raddr", 32'(raddr0), wp);
      chk("wrap nf r", 32'(nf0), 0);
      chk("wrap err r", 32'(ovf0 | udf0), 0);
    end
    chk("wrap final waddr", 32'(waddr0), 3);

    drive(0, 0, 0, 1);
    tick();
    chk("clr hiwater", 32'(hw0), 0);
    chk("clr ovf_sticky", 32'(ovs0), 0);
    chk("clr udf_sticky", 32'(uds0), 0);

    // Fill 5 then flush with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    chk("pre-flush numfilled", 32'(nf0), 5);
    chk("pre-flush hiwater", 32'(hw0), 5);
    chk("pre-flush afull", 32'(afull0), 1);
    chk("pre-flush full", 32'(full0), 0);
    drive(1, 0, 1, 0);
    chk("flush wen0", 32'(wen0), 0);
    chk("flush wen1", 32'(wen1), 0);
    tick();
    chk("flush numfilled", 32'(nf0), 0);
    chk("flush numempty", 32'(ne0), D);
    chk("flush waddr", 32'(waddr0), 0);
    chk("flush raddr", 32'(raddr0), 0);
    chk("flush empty", 32'(empty0), 1);
    chk("flush aempty", 32'(aempty0), 1);
    chk("flush afull", 32'(afull0), 0);
    chk("flush hiwater", 32'(hw0), 5);
    chk("flush overflow", 32'(ovf0), 0);

    // Error in the same cycle as clr_stat keeps the sticky set.
    drive(0, 1, 0, 1);
    tick();
    chk("clr+udf sticky", 32'(uds0), 1);
    chk("clr+udf pulse", 32'(udf0), 1);
    chk("clr+udf hiwater", 32'(hw0), 0);
    drive(0, 0, 0, 1);
    tick();
    chk("clr2 udf_sticky", 32'(uds0), 0);
    chk("clr2 underflow", 32'(udf0), 0);

    // Full with write and read together: both accepted, no overflow.
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    chk("refill full", 32'(full0), 1);
    drive(1, 1, 0, 0);
    chk("full wr+rd wen", 32'(wen0), 1);
    tick();
    chk("full wr+rd numfilled0", 32'(nf0), D);
    chk("full wr+rd full0", 32'(full0), 1);
    chk("full wr+rd ovf0", 32'(ovf0), 0);
    chk("full wr+rd ovf1", 32'(ovf1), 0);
    chk("full wr+rd waddr0", 32'(waddr0), 1);
    chk("full wr+rd raddr0", 32'(raddr0), 1);
    chk("full wr+rd numfilled1", 32'(nf1), D);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    chk("mid numfilled", 32'(nf0), 3);
    chk("mid raddr", 32'(raddr0), 4);

    // Reset mid-burst overrides the write.
    rst = 1'b1;
    drive(1, 0, 0, 0);
    chk("rst wen", 32'(wen0), 0);
    tick();
    chk_reset_state("midrst");
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
